// File: rtl/fp16_add_reduce_ctrl_if.sv
// Bundle of the element stream, sum stream and external adder signals.
// master: the reduction controller; slave: its environment.
interface fp16_add_reduce_ctrl_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_sum;
   logic [CNT_W-1:0]  out_count;
   logic              add_start;
   logic [DATA_W-1:0] add_in1;
   logic [DATA_W-1:0] add_in2;
   logic [DATA_W-1:0] add_result;
   logic              busy;

   modport master (
      input  in_valid, in_data, in_last, out_ready, add_result,
      output in_ready, out_valid, out_sum, out_count, add_start, add_in1, add_in2, busy
   );

   modport slave (
      output in_valid, in_data, in_last, out_ready, add_result,
      input  in_ready, out_valid, out_sum, out_count, add_start, add_in1, add_in2, busy
   );
endinterface

// File: rtl/fp16_add_reduce_ctrl.sv
// Reduces each packet of FP16 elements to one sum by sequencing serial requests
// to an external fixed-latency adder. No arithmetic is done here.
module fp16_add_reduce_ctrl #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADD_LAT = 3,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                  CLK,
   input  logic                  nRST,
   fp16_add_reduce_ctrl_if.master bus
);
   localparam int unsigned WCNT_W = $clog2(ADD_LAT + 1);
   localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(ADD_LAT);

   typedef enum logic [1:0] {StIdle, StFetch, StWait, StDone} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_q, last_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [DATA_W-1:0] in1_q, in1_d;
   logic [DATA_W-1:0] in2_q, in2_d;
   logic              start_q, start_d;
   logic              in_ready;
   logic              in_xfer;

   assign in_ready = (state_q == StIdle) || (state_q == StFetch);
   assign in_xfer  = bus.in_valid && in_ready;

   // Next-state and datapath register updates.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      wcnt_d  = wcnt_q;
      in1_d   = in1_q;
      in2_d   = in2_q;
      start_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (in_xfer) begin
               acc_d   = bus.in_data;
               cnt_d   = CNT_W'(1);
               state_d = bus.in_last ? StDone : StFetch;
            end
         end
         StFetch: begin
            if (in_xfer) begin
               in1_d   = acc_q;
               in2_d   = bus.in_data;
               last_d  = bus.in_last;
               // Count saturates; accumulation carries on regardless.
               cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
               wcnt_d  = WCNT_INIT;
               start_d = 1'b1;
               state_d = StWait;
            end
         end
         StWait: begin
            // Result is valid in the last of the ADD_LAT wait cycles.
            if (wcnt_q == WCNT_W'(1)) begin
               acc_d   = bus.add_result;
               state_d = last_q ? StDone : StFetch;
            end else begin
               wcnt_d = wcnt_q - WCNT_W'(1);
            end
         end
         StDone: begin
            if (bus.out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         wcnt_q  <= '0;
         in1_q   <= '0;
         in2_q   <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         wcnt_q  <= wcnt_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         start_q <= start_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == StDone);
   assign bus.out_sum   = acc_q;
   assign bus.out_count = cnt_q;
   assign bus.add_start = start_q;
   assign bus.add_in1   = in1_q;
   assign bus.add_in2   = in2_q;
   assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_fp16_add_reduce_ctrl.sv
// Directed bench for fp16_add_reduce_ctrl with a table-driven model adder.
module tb_fp16_add_reduce_ctrl;
   localparam int DATA_W    = 16;
   localparam int ADD_LAT   = 3;
   localparam int CNT_W     = 8;
   localparam int CNT_W_SAT = 4;

   logic CLK  = 1'b0;
   logic nRST = 1'b1;
   always #5 CLK = ~CLK;

   fp16_add_reduce_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W))     bus ();
   fp16_add_reduce_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W_SAT)) bus4 ();

   fp16_add_reduce_ctrl #(.DATA_W(DATA_W), .ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   fp16_add_reduce_ctrl #(.DATA_W(DATA_W), .ADD_LAT(ADD_LAT), .CNT_W(CNT_W_SAT)) dut4 (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus4)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int pulses = 0;
   int pulses4 = 0;
   logic [31:0] pairs[$];

   logic [15:0] pkt[32];
   int          pkt_n;

   // Cycle counter, add_start pulse counters and operand log.
   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (bus.add_start) begin
         pulses <= pulses + 1;
         pairs.push_back({bus.add_in1, bus.add_in2});
      end
      if (bus4.add_start) pulses4 <= pulses4 + 1;
   end

   // Model adder: sums known operand pairs; garbage outside the result cycle.
   function automatic logic [15:0] model_sum(input logic [15:0] a, input logic [15:0] b);
      case ({a, b})
         32'h3C00_4000: return 16'h4200;
         32'h4200_4200: return 16'h4600;
         32'h4600_4400: return 16'h4900;
         32'h4000_4000: return 16'h4400;
         default:       return 16'hFFFF;
      endcase
   endfunction

   logic [15:0] m_a = '0;
   logic [15:0] m_b = '0;
   int          m_stage = 0;
   always @(posedge CLK) begin
      if (bus.add_start) begin
         m_a     <= bus.add_in1;
         m_b     <= bus.add_in2;
         m_stage <= 1;
      end else if (m_stage != 0 && m_stage < ADD_LAT) begin
         m_stage <= m_stage + 1;
      end
   end
   assign bus.add_result  = (m_stage == ADD_LAT - 1) ? model_sum(m_a, m_b) : 16'hDEAD;
   assign bus4.add_result = 16'h0000;

   // Offers pkt[0..pkt_n-1] on bus, withholding valid for 'gap' FETCH cycles after
   // each accepted element; returns first-accept-to-out_valid latency or -1.
   task automatic drive_packet(input int gap, output int lat);
      int idx = 0;
      int t0 = 0;
      int gap_left = 0;
      int budget = 400;
      lat = -1;
      while (idx < pkt_n && budget > 0) begin
         @(negedge CLK);
         budget--;
         if (bus.in_ready && gap_left > 0) begin
            bus.in_valid = 1'b0;
            gap_left--;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = pkt[idx];
            bus.in_last  = (idx == pkt_n - 1);
            if (bus.in_ready) begin
               if (idx == 0) t0 = cyc;
               idx++;
               gap_left = gap;
            end
         end
      end
      do begin
         @(negedge CLK);
         bus.in_valid = 1'b0;
         budget--;
      end while (!bus.out_valid && budget > 0);
      if (bus.out_valid) lat = cyc - t0;
   endtask

   task automatic handshake();
      @(negedge CLK);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      @(negedge CLK);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_after got=%b exp=1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.add_start !== 1'b0) begin errors++; $display("FAIL rst_add_start got=%b exp=0", bus.add_start); end
      checks++; if (bus.add_in1 !== 16'h0) begin errors++; $display("FAIL rst_add_in1 got=%h exp=0000", bus.add_in1); end
      checks++; if (bus.add_in2 !== 16'h0) begin errors++; $display("FAIL rst_add_in2 got=%h exp=0000", bus.add_in2); end
      checks++; if (bus.out_sum !== 16'h0) begin errors++; $display("FAIL rst_out_sum got=%h exp=0000", bus.out_sum); end
      checks++; if (bus.out_count !== 8'h0) begin errors++; $display("FAIL rst_out_count got=%0d exp=0", bus.out_count); end
   endtask

   task automatic test_single();
      int lat;
      int p0 = pulses;
      pkt[0] = 16'h3C00;
      pkt_n  = 1;
      drive_packet(0, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL single_latency got=%0d exp=1", lat); end
      checks++; if (bus.out_sum !== 16'h3C00) begin errors++; $display("FAIL single_sum got=%h exp=3c00", bus.out_sum); end
      checks++; if (bus.out_count !== 8'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", bus.out_count); end
      checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL single_pulses got=%0d exp=0", pulses - p0); end
      handshake();
   endtask

   task automatic test_four();
      int lat;
      int p0 = pulses;
      int q0 = pairs.size();
      logic [31:0] pexp[3];
      logic [31:0] got;
      pexp[0] = 32'h3C00_4000;
      pexp[1] = 32'h4200_4200;
      pexp[2] = 32'h4600_4400;
      pkt[0] = 16'h3C00; pkt[1] = 16'h4000; pkt[2] = 16'h4200; pkt[3] = 16'h4400;
      pkt_n  = 4;
      drive_packet(0, lat);
      checks++; if (lat !== 13) begin errors++; $display("FAIL four_latency got=%0d exp=13", lat); end
      checks++; if (bus.out_sum !== 16'h4900) begin errors++; $display("FAIL four_sum got=%h exp=4900", bus.out_sum); end
      checks++; if (bus.out_count !== 8'd4) begin errors++; $display("FAIL four_count got=%0d exp=4", bus.out_count); end
      checks++; if (pulses - p0 !== 3) begin errors++; $display("FAIL four_pulses got=%0d exp=3", pulses - p0); end
      for (int i = 0; i < 3; i++) begin
         got = (q0 + i < pairs.size()) ? pairs[q0 + i] : 32'hFFFF_FFFF;
         checks++; if (got !== pexp[i]) begin errors++; $display("FAIL four_pair%0d got=%h exp=%h", i, got, pexp[i]); end
      end
      handshake();
   endtask

   task automatic test_backpressure();
      int lat;
      pkt[0] = 16'h3C00; pkt[1] = 16'h4000; pkt[2] = 16'h4200; pkt[3] = 16'h4400;
      pkt_n  = 4;
      drive_packet(2, lat);
      checks++; if (lat !== 19) begin errors++; $display("FAIL gap_latency got=%0d exp=19", lat); end
      checks++; if (bus.out_sum !== 16'h4900) begin errors++; $display("FAIL gap_sum got=%h exp=4900", bus.out_sum); end
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         bus.in_valid = 1'b1;
         bus.in_data  = 16'h7777;
         bus.in_last  = 1'b1;
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid%0d got=%b exp=1", i, bus.out_valid); end
         checks++; if (bus.out_sum !== 16'h4900) begin errors++; $display("FAIL hold_sum%0d got=%h exp=4900", i, bus.out_sum); end
         checks++; if (bus.out_count !== 8'd4) begin errors++; $display("FAIL hold_count%0d got=%0d exp=4", i, bus.out_count); end
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready%0d got=%b exp=0", i, bus.in_ready); end
      end
      handshake();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_release got=%b exp=0", bus.out_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_idle_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_wait_hold();
      int budget = 50;
      int p0 = pulses;
      @(negedge CLK);
      bus.in_valid = 1'b1; bus.in_data = 16'h3C00; bus.in_last = 1'b0;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL wh_idle_ready got=%b exp=1", bus.in_ready); end
      @(negedge CLK);
      bus.in_data = 16'h4000;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL wh_fetch_ready got=%b exp=1", bus.in_ready); end
      for (int i = 0; i < ADD_LAT; i++) begin
         @(negedge CLK);
         bus.in_valid = 1'b1;
         bus.in_data  = 16'h7000 + 16'(i);
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL wh_ready%0d got=%b exp=0", i, bus.in_ready); end
         checks++; if (bus.add_start !== (i == 0)) begin errors++; $display("FAIL wh_start%0d got=%b exp=%b", i, bus.add_start, (i == 0)); end
         checks++; if (bus.add_in1 !== 16'h3C00) begin errors++; $display("FAIL wh_in1_%0d got=%h exp=3c00", i, bus.add_in1); end
         checks++; if (bus.add_in2 !== 16'h4000) begin errors++; $display("FAIL wh_in2_%0d got=%h exp=4000", i, bus.add_in2); end
      end
      @(negedge CLK);
      bus.in_valid = 1'b1; bus.in_data = 16'h4200; bus.in_last = 1'b1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL wh_refetch_ready got=%b exp=1", bus.in_ready); end
      do begin
         @(negedge CLK);
         bus.in_valid = 1'b0;
         budget--;
      end while (!bus.out_valid && budget > 0);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL wh_done got=%b exp=1", bus.out_valid); end
      checks++; if (bus.out_sum !== 16'h4600) begin errors++; $display("FAIL wh_sum got=%h exp=4600", bus.out_sum); end
      checks++; if (bus.out_count !== 8'd3) begin errors++; $display("FAIL wh_count got=%0d exp=3", bus.out_count); end
      checks++; if (pulses - p0 !== 2) begin errors++; $display("FAIL wh_pulses got=%0d exp=2", pulses - p0); end
      handshake();
   endtask

   task automatic test_reset_mid();
      int lat;
      @(negedge CLK);
      bus.in_valid = 1'b1; bus.in_data = 16'h3C00; bus.in_last = 1'b0;
      @(negedge CLK);
      bus.in_data = 16'h4000;
      @(negedge CLK);
      bus.in_valid = 1'b0;
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.add_in1 !== 16'h0) begin errors++; $display("FAIL mid_add_in1 got=%h exp=0000", bus.add_in1); end
      checks++; if (bus.add_in2 !== 16'h0) begin errors++; $display("FAIL mid_add_in2 got=%h exp=0000", bus.add_in2); end
      checks++; if (bus.out_sum !== 16'h0) begin errors++; $display("FAIL mid_out_sum got=%h exp=0000", bus.out_sum); end
      checks++; if (bus.out_count !== 8'h0) begin errors++; $display("FAIL mid_out_count got=%0d exp=0", bus.out_count); end
      @(negedge CLK);
      nRST = 1'b1;
      pkt[0] = 16'h4000; pkt[1] = 16'h4000;
      pkt_n  = 2;
      drive_packet(0, lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL mid_next_latency got=%0d exp=5", lat); end
      checks++; if (bus.out_sum !== 16'h4400) begin errors++; $display("FAIL mid_next_sum got=%h exp=4400", bus.out_sum); end
      checks++; if (bus.out_count !== 8'd2) begin errors++; $display("FAIL mid_next_count got=%0d exp=2", bus.out_count); end
      handshake();
   endtask

   task automatic test_saturation();
      int idx = 0;
      int budget = 600;
      int p0 = pulses4;
      while (idx < 20 && budget > 0) begin
         @(negedge CLK);
         budget--;
         bus4.in_valid = 1'b1;
         bus4.in_data  = 16'h0000;
         bus4.in_last  = (idx == 19);
         if (bus4.in_ready) idx++;
      end
      do begin
         @(negedge CLK);
         bus4.in_valid = 1'b0;
         budget--;
      end while (!bus4.out_valid && budget > 0);
      checks++; if (bus4.out_valid !== 1'b1) begin errors++; $display("FAIL sat_done got=%b exp=1", bus4.out_valid); end
      checks++; if (bus4.out_count !== 4'hF) begin errors++; $display("FAIL sat_count got=%0d exp=15", bus4.out_count); end
      checks++; if (bus4.out_sum !== 16'h0000) begin errors++; $display("FAIL sat_sum got=%h exp=0000", bus4.out_sum); end
      checks++; if (pulses4 - p0 !== 19) begin errors++; $display("FAIL sat_pulses got=%0d exp=19", pulses4 - p0); end
      @(negedge CLK);
      bus4.out_ready = 1'b1;
      @(negedge CLK);
      bus4.out_ready = 1'b0;
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_last    = 1'b0;
      bus.out_ready  = 1'b0;
      bus4.in_valid  = 1'b0;
      bus4.in_data   = '0;
      bus4.in_last   = 1'b0;
      bus4.out_ready = 1'b0;
      test_reset();
      test_single();
      test_four();
      test_backpressure();
      test_wait_hold();
      test_reset_mid();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
